// File: rtl/seq_det_pkg.sv
// Shared definitions for the "1010" overlapping Mealy detector.
//   det_state_t : 2-bit detector state (S0 = nothing matched .. S3 = "101" matched)
//   det_next()  : one detector step, returns {next_state, hit}
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  // Each state is the longest suffix of the bits seen so far that is also a prefix
  // of "1010". The hit leaves us in S2 because the trailing "10" of a hit can
  // begin the next match.
  function automatic logic [2:0] det_next(input det_state_t st, input logic b);
    det_state_t ns;
    logic       hit;
    ns  = S0;
    hit = 1'b0;
    case (st)
      S0: ns = b ? S1 : S0;
      S1: ns = b ? S1 : S2;
      S2: ns = b ? S3 : S0;
      S3: begin
        ns  = b ? S1 : S2;
        hit = ~b;
      end
      default: ns = S0;
    endcase
    return {ns, hit};
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin arbiter for the shared detector.
//   ch_valid  : per-channel request
//   enable    : 0 forces no grant
//   ptr       : last granted channel; the search starts at ptr+1 (mod NUM_CH)
//   grant     : one-hot grant
//   grant_idx : index of the granted channel (0 when none)
//   grant_vld : a grant was issued this cycle
module seq_det_rr_arb
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic              enable,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  always_comb begin
    int              cand;
    logic [CH_W-1:0] cidx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cidx      = '0;
    // Visit ptr+1 .. ptr+NUM_CH; the last candidate is ptr itself, so a lone
    // requester is granted back to back.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(ptr) + k) % NUM_CH;
      cidx = CH_W'(cand);
      if (enable && !grant_vld && ch_valid[cidx]) begin
        grant_vld   = 1'b1;
        grant_idx   = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one "1010" overlapping detector between NUM_CH serial channels.
//   clk, rst  : clock; asynchronous active-low reset
//   enable    : allow arbitration
//   clr_ctx   : synchronous clear of all contexts and the hit counter
//   ch_valid  : channel offers a bit;  ch_bit : the offered bit
//   ch_ready  : one-hot combinational grant; a bit is consumed on valid & ready
//   det_valid : 1-cycle pulse after a consumed bit completes "1010"
//   det_ch    : channel of the last hit (holds between hits)
//   hit_count : saturating count of hits since reset / clr_ctx
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_ctx,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              det_valid,
  output logic [CH_W-1:0]   det_ch,
  output logic [CNT_W-1:0]  hit_count
);

  det_state_t       ctx_q [NUM_CH];
  det_state_t       ctx_d [NUM_CH];
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             det_valid_q, det_valid_d;
  logic [CH_W-1:0]  det_ch_q, det_ch_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  logic             arb_en;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_vld;
  logic [2:0]       step;

  // rst is folded in so no grant is visible while reset is asserted; clr_ctx
  // blocks grants because a cleared cycle must not consume a bit.
  assign arb_en = enable & ~clr_ctx & rst;

  seq_det_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .ch_valid  (ch_valid),
    .enable    (arb_en),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  always_comb begin
    ctx_d       = ctx_q;
    ptr_d       = ptr_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    hit_count_d = hit_count_q;
    step        = det_next(ctx_q[gnt_idx], ch_bit[gnt_idx]);
    if (clr_ctx) begin
      for (int i = 0; i < NUM_CH; i++) ctx_d[i] = S0;
      hit_count_d = '0;
    end else if (gnt_vld) begin
      ptr_d          = gnt_idx;
      ctx_d[gnt_idx] = det_state_t'(step[2:1]);
      if (step[0]) begin
        det_valid_d = 1'b1;
        det_ch_d    = gnt_idx;
        if (!(&hit_count_q)) hit_count_d = hit_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) ctx_q[i] <= S0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      hit_count_q <= '0;
    end else begin
      ctx_q       <= ctx_d;
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign ch_ready  = gnt;
  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign hit_count = hit_count_q;

endmodule
